us_timer_sched: RTL



---
 rtl/us_timer_sched.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/us_timer_sched.sv
// Multi-channel microsecond timer: NCH channels share the 1 us tick, each one-shot or periodic.
// Optional `US_TIMER_SCHED_MS_PRESCALE_EN adds a 1000:1 prescaler so channels can count in ms.
module us_timer_sched #(
  parameter int unsigned NCH = 4,
  parameter int unsigned CW  = 16
) (
  input  logic           clk6x,
  input  logic           resetn,
  input  logic           ck1us_i,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic [2:0]     cmd_ch,
  input  logic [1:0]     cmd_op,
  input  logic           cmd_unit,
  input  logic [CW-1:0]  cmd_value,
  output logic [NCH-1:0] active,
  output logic [NCH-1:0] expired
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ONESHOT  = 2'd1,
    ST_PERIODIC = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_NOP            = 2'd0,
    OP_START_ONESHOT  = 2'd1,
    OP_START_PERIODIC = 2'd2,
    OP_STOP           = 2'd3
  } op_t;

  state_t          state_q  [NCH];
  state_t          state_n  [NCH];
  logic [CW-1:0]   cnt_q    [NCH];
  logic [CW-1:0]   cnt_n    [NCH];
  logic [CW-1:0]   reload_q [NCH];
  logic [CW-1:0]   reload_n [NCH];
  logic [NCH-1:0]  exp_q;
  logic [NCH-1:0]  exp_n;
  logic [NCH-1:0]  chan_tick;
  logic            ready_q;
  logic            accept;
  op_t             op;

  assign op = op_t'(cmd_op);

  always_ff @(posedge clk6x or negedge resetn) begin
    if (!resetn) ready_q <= 1'b0;
    else         ready_q <= 1'b1;
  end

  // Commands are held off during tick cycles so they never race the count update.
  assign cmd_ready = ready_q & ~ck1us_i;
  assign accept    = cmd_valid & cmd_ready;

`ifdef US_TIMER_SCHED_MS_PRESCALE_EN
  logic [9:0]     presc_q;
  logic           ms_tick;
  logic [NCH-1:0] unit_q;
  logic [NCH-1:0] unit_n;

  assign ms_tick = ck1us_i && (presc_q == 10'd999);

  always_ff @(posedge clk6x or negedge resetn) begin
    if (!resetn)      presc_q <= '0;
    else if (ck1us_i) presc_q <= ms_tick ? '0 : presc_q + 10'd1;
  end

  always_comb begin
    for (int unsigned i = 0; i < NCH; i++)
      chan_tick[i] = unit_q[i] ? ms_tick : ck1us_i;
  end
`else
  logic unused_cmd_unit;
  assign unused_cmd_unit = cmd_unit;
  assign chan_tick = {NCH{ck1us_i}};
`endif

  always_comb begin
    for (int unsigned i = 0; i < NCH; i++) begin
      state_n[i]  = state_q[i];
      cnt_n[i]    = cnt_q[i];
      reload_n[i] = reload_q[i];
      exp_n[i]    = 1'b0;
`ifdef US_TIMER_SCHED_MS_PRESCALE_EN
      unit_n[i]   = unit_q[i];
`endif
      if (accept && (cmd_ch == 3'(i))) begin
        case (op)
          OP_START_ONESHOT, OP_START_PERIODIC: begin
            if (cmd_value != '0) begin
              state_n[i]  = (op == OP_START_ONESHOT) ? ST_ONESHOT : ST_PERIODIC;
              cnt_n[i]    = cmd_value;
              reload_n[i] = cmd_value;
`ifdef US_TIMER_SCHED_MS_PRESCALE_EN
              unit_n[i]   = cmd_unit;
`endif
            end else begin
              state_n[i] = ST_IDLE;
              exp_n[i]   = 1'b1;
            end
          end
          OP_STOP: state_n[i] = ST_IDLE;
          default: ;
        endcase
      end else if ((state_q[i] != ST_IDLE) && chan_tick[i]) begin
        if (cnt_q[i] > CW'(1)) begin
          cnt_n[i] = cnt_q[i] - CW'(1);
        end else begin
          exp_n[i] = 1'b1;
          if (state_q[i] == ST_ONESHOT) state_n[i] = ST_IDLE;
          else                          cnt_n[i]   = reload_q[i];
        end
      end
    end
  end

  always_ff @(posedge clk6x or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        state_q[i]  <= ST_IDLE;
        cnt_q[i]    <= '0;
        reload_q[i] <= '0;
      end
      exp_q <= '0;
`ifdef US_TIMER_SCHED_MS_PRESCALE_EN
      unit_q <= '0;
`endif
    end else begin
      for (int unsigned i = 0; i < NCH; i++) begin
        state_q[i]  <= state_n[i];
        cnt_q[i]    <= cnt_n[i];
        reload_q[i] <= reload_n[i];
      end
      exp_q <= exp_n;
`ifdef US_TIMER_SCHED_MS_PRESCALE_EN
      unit_q <= unit_n;
`endif
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NCH; i++)
      active[i] = (state_q[i] != ST_IDLE);
  end

  assign expired = exp_q;

endmodule
